// File: rtl/idelay_tap_scheduler.sv
// IDELAYCTRL bring-up sequencer plus a round-robin arbiter that shares one
// IDELAYE2 VAR_LOAD tap-load path across NUM_LANES lanes, with readback check.
module idelay_tap_scheduler #(
  parameter int NUM_LANES   = 4,
  parameter int INIT_CYCLES = 20000,
  parameter int RST_CYCLES  = 12,
  parameter int RDY_TIMEOUT = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   idctl_rst,
  input  logic                   idctl_rdy,
  output logic                   ready,
  input  logic [NUM_LANES-1:0]   req,
  input  logic [5*NUM_LANES-1:0] tap_in,
  output logic [NUM_LANES-1:0]   ack,
  output logic                   err,
  output logic [NUM_LANES-1:0]   ld,
  output logic [4:0]             cntvaluein,
  input  logic [5*NUM_LANES-1:0] cntvalueout,
  output logic [7:0]             timeout_cnt
);
  localparam int GW    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int CMAX0 = (INIT_CYCLES > RDY_TIMEOUT) ? INIT_CYCLES : RDY_TIMEOUT;
  localparam int CMAX  = (CMAX0 > RST_CYCLES) ? CMAX0 : RST_CYCLES;
  localparam int CW    = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_RST_WAIT, S_RST_PULSE, S_WAIT_RDY, S_IDLE, S_LOAD, S_SETTLE, S_CHECK, S_ACK
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [GW-1:0]        grant_q, grant_d, ptr_q, ptr_d, pick;
  logic [GW:0]          lane;
  logic                 found;
  logic [4:0]           cv_q, cv_d, tap_sel, rb_sel;
  logic                 errp_q, errp_d;
  logic [7:0]           tmo_q, tmo_d;
  logic                 rst_q, rst_d, ready_q, ready_d, err_q, err_d;
  logic [NUM_LANES-1:0] ld_q, ld_d, ack_q, ack_d;

  function automatic logic [NUM_LANES-1:0] onehot(input logic [GW-1:0] g);
    logic [NUM_LANES-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_LANES; i++) if (g == GW'(i)) v[i] = 1'b1;
    return v;
  endfunction

  // First requesting lane at or after the round-robin pointer, with wrap.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    lane  = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      lane = {1'b0, ptr_q} + (GW+1)'(k);
      if (lane >= (GW+1)'(NUM_LANES)) lane = lane - (GW+1)'(NUM_LANES);
      if (!found && req[lane[GW-1:0]]) begin
        found = 1'b1;
        pick  = lane[GW-1:0];
      end
    end
  end

  always_comb begin
    tap_sel = '0;
    rb_sel  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (pick == GW'(i))    tap_sel = tap_in[5*i +: 5];
      if (grant_q == GW'(i)) rb_sel  = cntvalueout[5*i +: 5];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cv_d    = cv_q;
    errp_d  = errp_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_RST_WAIT: begin
        if (cnt_q == CW'(INIT_CYCLES - 1)) begin
          state_d = S_RST_PULSE;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CW'(1);
      end
      S_RST_PULSE: begin
        if (cnt_q == CW'(RST_CYCLES - 1)) begin
          state_d = S_WAIT_RDY;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CW'(1);
      end
      S_WAIT_RDY: begin
        if (idctl_rdy) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(RDY_TIMEOUT - 1)) begin
          state_d = S_RST_PULSE;
          cnt_d   = '0;
          if (tmo_q != 8'hFF) tmo_d = tmo_q + 8'd1;
        end else cnt_d = cnt_q + CW'(1);
      end
      default: begin
        // The ack shown in ACK commits the load, so the pointer advances even if RDY drops there.
        if (state_q == S_ACK)
          ptr_d = (grant_q == GW'(NUM_LANES - 1)) ? '0 : grant_q + GW'(1);
        if (!idctl_rdy) begin
          state_d = S_RST_PULSE;
          cnt_d   = '0;
        end else begin
          case (state_q)
            S_IDLE: if (found) begin
              grant_d = pick;
              cv_d    = tap_sel;
              state_d = S_LOAD;
            end
            S_LOAD:   state_d = S_SETTLE;
            S_SETTLE: state_d = S_CHECK;
            S_CHECK: begin
              errp_d  = (rb_sel != cv_q);
              state_d = S_ACK;
            end
            default:  state_d = S_IDLE;
          endcase
        end
      end
    endcase

    rst_d   = (state_d == S_RST_PULSE);
    ready_d = state_d inside {S_IDLE, S_LOAD, S_SETTLE, S_CHECK, S_ACK};
    ld_d    = (state_d == S_LOAD) ? onehot(grant_d) : '0;
    ack_d   = (state_d == S_ACK) ? onehot(grant_d) : '0;
    err_d   = (state_d == S_ACK) && errp_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RST_WAIT;
      cnt_q   <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      cv_q    <= '0;
      errp_q  <= 1'b0;
      tmo_q   <= '0;
      rst_q   <= 1'b0;
      ready_q <= 1'b0;
      ld_q    <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cv_q    <= cv_d;
      errp_q  <= errp_d;
      tmo_q   <= tmo_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      ld_q    <= ld_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign idctl_rst   = rst_q;
  assign ready       = ready_q;
  assign ld          = ld_q;
  assign ack         = ack_q;
  assign err         = err_q;
  assign cntvaluein  = cv_q;
  assign timeout_cnt = tmo_q;
endmodule

// File: tb/tb_idelay_tap_scheduler.sv
// Scoreboard bench for idelay_tap_scheduler: stimulus queues expected loads/acks,
// a negedge monitor pops and compares whenever ld or ack is presented.
`timescale 1ns/1ps
module tb_idelay_tap_scheduler;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           idctl_rdy = 1'b0;
  logic [N-1:0]   req = '0;
  logic [5*N-1:0] tap_in = '0;
  logic           idctl_rst, ready, err;
  logic [N-1:0]   ack, ld;
  logic [4:0]     cntvaluein;
  logic [5*N-1:0] cntvalueout;
  logic [7:0]     timeout_cnt;
  logic [4:0]     echo [N];

  typedef struct packed { logic [N-1:0] vec; logic [4:0] cv; } ld_exp_t;
  typedef struct packed { logic [N-1:0] vec; logic e; } ack_exp_t;
  ld_exp_t  ldq[$];
  ack_exp_t ackq[$];
  ld_exp_t  ld_e;
  ack_exp_t ack_e;
  int ack_cycs[$];
  int checks = 0, failures = 0, cyc = 0, last_ld_cyc = 0, bad_lane = -1;
  logic [4:0] bad_val = '0;
  bit rereq0 = 1'b0;

  idelay_tap_scheduler #(.NUM_LANES(N), .INIT_CYCLES(20000), .RST_CYCLES(12), .RDY_TIMEOUT(4096)) dut (
    .clk(clk), .reset(reset), .idctl_rst(idctl_rst), .idctl_rdy(idctl_rdy), .ready(ready),
    .req(req), .tap_in(tap_in), .ack(ack), .err(err), .ld(ld), .cntvaluein(cntvaluein),
    .cntvalueout(cntvalueout), .timeout_cnt(timeout_cnt));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // IDELAYE2 readback model: latches CNTVALUEIN on LD, optionally corrupting one lane.
  always @(posedge clk)
    for (int i = 0; i < N; i++)
      if (ld[i]) echo[i] <= (i == bad_lane) ? bad_val : cntvaluein;
  for (genvar g = 0; g < N; g++) begin : g_rb
    assign cntvalueout[5*g +: 5] = echo[g];
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (ld != '0) begin
        if (ldq.size() == 0) chk("ld_unexpected", ld, 0);
        else begin
          ld_e = ldq.pop_front();
          chk("ld_vec", ld, ld_e.vec);
          chk("ld_cntvaluein", cntvaluein, ld_e.cv);
        end
        last_ld_cyc = cyc;
      end
      if (ack != '0) begin
        if (ackq.size() == 0) chk("ack_unexpected", ack, 0);
        else begin
          ack_e = ackq.pop_front();
          chk("ack_vec", ack, ack_e.vec);
          chk("ack_err", err, ack_e.e);
          chk("ld_to_ack_latency", cyc - last_ld_cyc, 3);
        end
      end
      if (err && ack == '0) chk("err_without_ack", err, 0);
    end
  end

  task automatic expect_load(input int lane, input int tap);
    ld_exp_t x;
    x.vec = N'(1) << lane;
    x.cv  = 5'(tap);
    ldq.push_back(x);
  endtask

  task automatic expect_ack(input int lane, input bit e);
    ack_exp_t x;
    x.vec = N'(1) << lane;
    x.e   = e;
    ackq.push_back(x);
  endtask

  task automatic measure_pulse(output int len);
    len = 0;
    while (idctl_rst && len < 100) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic wait_rst_rise(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!idctl_rst && n < budget);
  endtask

  task automatic wait_acks(input int n, input int budget);
    int seen = 0;
    int t = 0;
    while (seen < n && t < budget) begin
      @(negedge clk);
      t++;
      for (int i = 0; i < N; i++) if (ack[i]) begin
        seen++;
        ack_cycs.push_back(cyc);
        if (i == 0 && rereq0) begin
          rereq0 = 1'b0;
          tap_in[4:0] = 5'd5;
        end else req[i] = 1'b0;
      end
    end
    if (seen < n) chk("ack_wait_budget", seen, n);
  endtask

  initial begin
    int n, len, c;
    repeat (3) @(negedge clk);
    chk("rst_idctl_rst", idctl_rst, 0);
    chk("rst_ready", ready, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_ld", ld, 0);
    chk("rst_cntvaluein", cntvaluein, 0);
    chk("rst_timeout_cnt", timeout_cnt, 0);
    reset = 1'b0;

    // Power-up wait, first pulse, then no RDY until a timeout forces a second pulse.
    wait_rst_rise(30000, n);
    chk("init_cycles", n, 20000);
    measure_pulse(len);
    chk("pulse1_len", len, 12);
    chk("ready_during_wait", ready, 0);
    wait_rst_rise(10000, n);
    chk("rdy_timeout_cycles", n, 4096);
    chk("timeout_cnt_after_timeout", timeout_cnt, 1);
    measure_pulse(len);
    chk("pulse2_len", len, 12);
    idctl_rdy = 1'b1;
    chk("ready_before_rdy", ready, 0);
    @(negedge clk);
    chk("ready_after_rdy", ready, 1);
    chk("timeout_cnt_kept", timeout_cnt, 1);

    // Single load, lane 2, tap 17; a later tap_in change must be ignored.
    ack_cycs.delete();
    c = cyc;
    req[2] = 1'b1;
    tap_in[14:10] = 5'd17;
    expect_load(2, 17);
    expect_ack(2, 1'b0);
    @(negedge clk);
    tap_in[14:10] = 5'd9;
    wait_acks(1, 20);
    if (ack_cycs.size() > 0) chk("grant_to_ack", ack_cycs[0] - c, 4);

    // Lane 3 with tap 0 wraps the pointer back to 0.
    req[3] = 1'b1;
    tap_in[19:15] = 5'd0;
    expect_load(3, 0);
    expect_ack(3, 1'b0);
    wait_acks(1, 20);

    // All four lanes at once; lane 0 re-requests and is served after lane 3.
    ack_cycs.delete();
    tap_in = {5'd31, 5'd21, 5'd9, 5'd3};
    req = 4'b1111;
    rereq0 = 1'b1;
    expect_load(0, 3);  expect_ack(0, 1'b0);
    expect_load(1, 9);  expect_ack(1, 1'b0);
    expect_load(2, 21); expect_ack(2, 1'b0);
    expect_load(3, 31); expect_ack(3, 1'b0);
    expect_load(0, 5);  expect_ack(0, 1'b0);
    wait_acks(5, 60);
    chk("rr_ack_count", ack_cycs.size(), 5);
    for (int i = 1; i < ack_cycs.size(); i++) chk("rr_ack_spacing", ack_cycs[i] - ack_cycs[i-1], 5);

    // Readback mismatch on lane 1.
    bad_lane = 1;
    bad_val = 5'd16;
    req[1] = 1'b1;
    tap_in[9:5] = 5'd15;
    expect_load(1, 15);
    expect_ack(1, 1'b1);
    wait_acks(1, 20);
    bad_lane = -1;

    // RDY lost during SETTLE of lane 3: abort, re-pulse, then reload lane 3.
    @(negedge clk);
    req[3] = 1'b1;
    tap_in[19:15] = 5'd12;
    expect_load(3, 12);
    @(negedge clk);
    @(negedge clk);
    idctl_rdy = 1'b0;
    @(negedge clk);
    chk("abort_idctl_rst", idctl_rst, 1);
    chk("abort_ready", ready, 0);
    chk("abort_ack", ack, 0);
    measure_pulse(len);
    chk("abort_pulse_len", len, 12);
    idctl_rdy = 1'b1;
    expect_load(3, 12);
    expect_ack(3, 1'b0);
    wait_acks(1, 30);
    chk("timeout_cnt_after_abort", timeout_cnt, 1);

    // Asynchronous reset in the middle of a load.
    @(negedge clk);
    req[0] = 1'b1;
    tap_in[4:0] = 5'd7;
    expect_load(0, 7);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("areset_ld", ld, 0);
    chk("areset_ready", ready, 0);
    chk("areset_cntvaluein", cntvaluein, 0);
    chk("areset_timeout_cnt", timeout_cnt, 0);
    chk("areset_idctl_rst", idctl_rst, 0);
    req = '0;
    @(negedge clk);
    reset = 1'b0;
    wait_rst_rise(30000, n);
    chk("reinit_cycles", n, 20000);

    chk("ld_queue_drained", ldq.size(), 0);
    chk("ack_queue_drained", ackq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
